// File: rtl/jbox_coord_parser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jbox_pkg
//  Purpose  : Shared constants and types for the junction-box coordinate
//             parser and the downstream distance/union stage.
//  Revision : 1.0  initial release
// ============================================================================
package jbox_pkg;

    localparam int NUM_ELEMENT = 1000;
    localparam int COORD_WIDTH = 17;
    localparam int ADDR_WIDTH  = 10;

    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_FORMAT   = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_LIMIT    = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARSE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FLD_X = 2'd0,
        FLD_Y = 2'd1,
        FLD_Z = 2'd2
    } field_t;

endpackage
`default_nettype wire

// File: rtl/jbox_coord_parser_if.sv
`default_nettype none
// ============================================================================
//  Module   : jbox_coord_parser_if
//  Purpose  : Byte-stream input and coordinate-RAM write port of the parser.
//  Revision : 1.0  initial release
// ============================================================================
interface jbox_coord_parser_if #(
    parameter int COORD_WIDTH = 17,
    parameter int ADDR_WIDTH  = 10
);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [COORD_WIDTH-1:0] wr_x;
    logic [COORD_WIDTH-1:0] wr_y;
    logic [COORD_WIDTH-1:0] wr_z;

    // Parser side: consumes bytes, produces RAM writes
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, wr_en, wr_addr, wr_x, wr_y, wr_z
    );

    // Byte source / RAM side
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, wr_en, wr_addr, wr_x, wr_y, wr_z
    );
endinterface
`default_nettype wire

// File: rtl/jbox_coord_parser_dec_accum.sv
`default_nettype none
// ============================================================================
//  Module   : jbox_dec_accum
//  Purpose  : Decimal field accumulator (value = value*10 + digit) with
//             overflow detection; shared by the X, Y and Z fields.
//  Revision : 1.0  initial release
// ============================================================================
module jbox_dec_accum #(
    parameter int COORD_WIDTH = 17
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   clear,
    input  wire logic [3:0]             digit,
    input  wire logic                   digit_en,
    output logic [COORD_WIDTH-1:0]      value,
    output logic [COORD_WIDTH-1:0]      next_value,
    output logic                        has_digit,
    output logic                        overflow
);

    logic [COORD_WIDTH-1:0] acc;
    logic                   seen;
    logic [COORD_WIDTH+3:0] acc_w;
    logic [COORD_WIDTH+3:0] prod;

    // Four guard bits hold acc*10+9 without wrapping, so the compare is exact
    assign acc_w      = {4'b0000, acc};
    assign prod       = (acc_w << 3) + (acc_w << 1) + {{COORD_WIDTH{1'b0}}, digit};
    assign overflow   = digit_en && (prod > {4'b0000, {COORD_WIDTH{1'b1}}});
    assign next_value = prod[COORD_WIDTH-1:0];
    assign value      = acc;
    assign has_digit  = seen;

    // Accumulate digits; clear wins so a field boundary always starts at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            seen <= 1'b0;
        end else if (clear) begin
            acc  <= '0;
            seen <= 1'b0;
        end else if (digit_en && !overflow) begin
            acc  <= prod[COORD_WIDTH-1:0];
            seen <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jbox_coord_parser.sv
`default_nettype none
// ============================================================================
//  Module   : jbox_coord_parser
//  Purpose  : Parses "x,y,z\n" ASCII records into indexed coordinate RAM
//             writes; reports record count, completion and format errors.
//  Revision : 1.0  initial release
// ============================================================================
module jbox_coord_parser
    import jbox_pkg::*;
#(
    parameter int NUM_ELEMENT = jbox_pkg::NUM_ELEMENT,
    parameter int COORD_WIDTH = jbox_pkg::COORD_WIDTH,
    parameter int ADDR_WIDTH  = jbox_pkg::ADDR_WIDTH
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            start,
    jbox_coord_parser_if.slave   bus,
    output logic [ADDR_WIDTH:0]  count,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code
);

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH+1)'(NUM_ELEMENT);

    state_t                 state,     state_nxt;
    field_t                 field,     field_nxt;
    err_code_t              err_q,     err_nxt;
    logic [COORD_WIDTH-1:0] x_q,       x_nxt;
    logic [COORD_WIDTH-1:0] y_q,       y_nxt;
    logic                   wr_en_q,   wr_en_nxt;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_nxt;
    logic [COORD_WIDTH-1:0] wr_x_q,    wr_x_nxt;
    logic [COORD_WIDTH-1:0] wr_y_q,    wr_y_nxt;
    logic [COORD_WIDTH-1:0] wr_z_q,    wr_z_nxt;
    logic [ADDR_WIDTH:0]    count_q,   count_nxt;
    logic                   done_q,    done_nxt;
    logic                   error_q,   error_nxt;

    logic                   acc_clear, digit_en;
    logic [COORD_WIDTH-1:0] acc_value, acc_next;
    logic                   acc_has_digit, acc_overflow;
    logic                   is_digit, fail, commit, hasd_after;
    err_code_t              fail_code;
    field_t                 field_after;
    logic [COORD_WIDTH-1:0] z_val;

    assign is_digit = (bus.in_data >= CH_0) && (bus.in_data <= CH_9);

    jbox_dec_accum #(.COORD_WIDTH(COORD_WIDTH)) u_accum (
        .clk        (clk),
        .rst        (rst),
        .clear      (acc_clear),
        .digit      (bus.in_data[3:0]),
        .digit_en   (digit_en),
        .value      (acc_value),
        .next_value (acc_next),
        .has_digit  (acc_has_digit),
        .overflow   (acc_overflow)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            field     <= FLD_X;
            err_q     <= ERR_NONE;
            x_q       <= '0;
            y_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_z_q    <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            field     <= field_nxt;
            err_q     <= err_nxt;
            x_q       <= x_nxt;
            y_q       <= y_nxt;
            wr_en_q   <= wr_en_nxt;
            wr_addr_q <= wr_addr_nxt;
            wr_x_q    <= wr_x_nxt;
            wr_y_q    <= wr_y_nxt;
            wr_z_q    <= wr_z_nxt;
            count_q   <= count_nxt;
            done_q    <= done_nxt;
            error_q   <= error_nxt;
        end
    end

    // Byte decode, field sequencing, record commit and termination
    always_comb begin
        state_nxt   = state;
        field_nxt   = field;
        err_nxt     = err_q;
        x_nxt       = x_q;
        y_nxt       = y_q;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr_q;
        wr_x_nxt    = wr_x_q;
        wr_y_nxt    = wr_y_q;
        wr_z_nxt    = wr_z_q;
        count_nxt   = count_q;
        done_nxt    = done_q;
        error_nxt   = error_q;
        acc_clear   = 1'b0;
        digit_en    = 1'b0;
        fail        = 1'b0;
        fail_code   = ERR_NONE;
        commit      = 1'b0;
        z_val       = acc_value;
        field_after = field;
        hasd_after  = acc_has_digit;

        if (state == ST_PARSE) begin
            if (bus.in_valid) begin
                if (is_digit) begin
                    digit_en   = 1'b1;
                    hasd_after = 1'b1;
                    if (acc_overflow) begin
                        fail      = 1'b1;
                        fail_code = ERR_OVERFLOW;
                    end
                end else if (bus.in_data == CH_COMMA) begin
                    if (acc_has_digit && field == FLD_X) begin
                        x_nxt       = acc_value;
                        field_nxt   = FLD_Y;
                        field_after = FLD_Y;
                        hasd_after  = 1'b0;
                        acc_clear   = 1'b1;
                    end else if (acc_has_digit && field == FLD_Y) begin
                        y_nxt       = acc_value;
                        field_nxt   = FLD_Z;
                        field_after = FLD_Z;
                        hasd_after  = 1'b0;
                        acc_clear   = 1'b1;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_FORMAT;
                    end
                end else if (bus.in_data == CH_NL) begin
                    if (field == FLD_Z && acc_has_digit) begin
                        commit      = 1'b1;
                        field_after = FLD_X;
                        hasd_after  = 1'b0;
                    end else if (!(field == FLD_X && !acc_has_digit)) begin
                        fail      = 1'b1;
                        fail_code = ERR_FORMAT;
                    end
                end else if (bus.in_data != CH_CR) begin
                    fail      = 1'b1;
                    fail_code = ERR_FORMAT;
                end

                // Final byte: a complete Z field without newline still commits
                if (!fail && bus.in_last && !commit) begin
                    if (field_after == FLD_Z && hasd_after) begin
                        commit = 1'b1;
                        z_val  = is_digit ? acc_next : acc_value;
                    end else if (!(field_after == FLD_X && !hasd_after)) begin
                        fail      = 1'b1;
                        fail_code = ERR_FORMAT;
                    end
                end

                if (commit && !fail) begin
                    if (count_q == MAX_COUNT) begin
                        fail      = 1'b1;
                        fail_code = ERR_LIMIT;
                    end else begin
                        wr_en_nxt   = 1'b1;
                        wr_addr_nxt = count_q[ADDR_WIDTH-1:0];
                        wr_x_nxt    = x_q;
                        wr_y_nxt    = y_q;
                        wr_z_nxt    = z_val;
                        count_nxt   = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                        field_nxt   = FLD_X;
                        acc_clear   = 1'b1;
                    end
                end

                if (fail) begin
                    state_nxt = ST_ERROR;
                    error_nxt = 1'b1;
                    err_nxt   = fail_code;
                end else if (bus.in_last) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end
            end
        end else if (start) begin
            state_nxt = ST_PARSE;
            field_nxt = FLD_X;
            x_nxt     = '0;
            y_nxt     = '0;
            count_nxt = '0;
            done_nxt  = 1'b0;
            error_nxt = 1'b0;
            err_nxt   = ERR_NONE;
            acc_clear = 1'b1;
        end
    end

    assign bus.in_ready = (state == ST_PARSE);
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_x     = wr_x_q;
    assign bus.wr_y     = wr_y_q;
    assign bus.wr_z     = wr_z_q;
    assign count        = count_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_jbox_coord_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jbox_coord_parser
//  Purpose  : Directed self-checking bench for jbox_coord_parser
//             (record limit reduced to 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_jbox_coord_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [10:0] count;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;

    // Write log captured away from the active edge
    int          n_wr = 0;
    logic [9:0]  log_addr [8];
    logic [16:0] log_x    [8];
    logic [16:0] log_y    [8];
    logic [16:0] log_z    [8];
    logic        log_done [8];
    int          wr_in_err = 0;

    jbox_coord_parser_if #(.COORD_WIDTH(17), .ADDR_WIDTH(10)) bif ();

    jbox_coord_parser #(.NUM_ELEMENT(4), .COORD_WIDTH(17), .ADDR_WIDTH(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bif),
        .count    (count),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // Record every RAM write strobe
    always @(negedge clk) begin
        if (bif.wr_en) begin
            if (n_wr < 8) begin
                log_addr[n_wr] = bif.wr_addr;
                log_x[n_wr]    = bif.wr_x;
                log_y[n_wr]    = bif.wr_y;
                log_z[n_wr]    = bif.wr_z;
                log_done[n_wr] = done;
            end
            if (error) wr_in_err = wr_in_err + 1;
            n_wr = n_wr + 1;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        n_wr      = 0;
        wr_in_err = 0;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // One byte per cycle; stops early once the parser drops in_ready
    task automatic send_str(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            if (!bif.in_ready) begin
                bif.in_valid = 1'b0;
                bif.in_last  = 1'b0;
                return;
            end
            bif.in_valid = 1'b1;
            bif.in_data  = s[i];
            bif.in_last  = last && (i == s.len() - 1);
        end
        @(negedge clk);
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bif.in_ready, bif.wr_en, done, error, err_code} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000000", {bif.in_ready, bif.wr_en, done, error, err_code});
        end
        checks++;
        if ({bif.wr_addr, bif.wr_x, bif.wr_y, bif.wr_z, count} !== '0) begin
            failures++;
            $display("FAIL reset_data: addr=%0d x=%0d y=%0d z=%0d count=%0d expected all 0",
                     bif.wr_addr, bif.wr_x, bif.wr_y, bif.wr_z, count);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: got %b expected 0", bif.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        send_str("162,817,812\n57,618,57\n", 1'b1);
        settle();
        checks++;
        if (n_wr !== 2) begin
            failures++;
            $display("FAIL b2b_nwr: got %0d expected 2", n_wr);
        end
        checks++;
        if ({log_addr[0], log_x[0], log_y[0], log_z[0]} !== {10'd0, 17'd162, 17'd817, 17'd812}) begin
            failures++;
            $display("FAIL b2b_rec0: got %0d %0d %0d %0d expected 0 162 817 812",
                     log_addr[0], log_x[0], log_y[0], log_z[0]);
        end
        checks++;
        if ({log_addr[1], log_x[1], log_y[1], log_z[1]} !== {10'd1, 17'd57, 17'd618, 17'd57}) begin
            failures++;
            $display("FAIL b2b_rec1: got %0d %0d %0d %0d expected 1 57 618 57",
                     log_addr[1], log_x[1], log_y[1], log_z[1]);
        end
        checks++;
        if ({count, done, error, bif.in_ready} !== {11'd2, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_status: count=%0d done=%b error=%b ready=%b expected 2 1 0 0",
                     count, done, error, bif.in_ready);
        end
        checks++;
        if ({log_done[0], log_done[1]} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_done_timing: got %b expected 01", {log_done[0], log_done[1]});
        end
    endtask

    task automatic test_no_newline();
        pulse_start();
        send_str("5,6,7", 1'b1);
        settle();
        checks++;
        if (n_wr !== 1) begin
            failures++;
            $display("FAIL nonl_nwr: got %0d expected 1", n_wr);
        end
        checks++;
        if ({log_addr[0], log_x[0], log_y[0], log_z[0], log_done[0]} !== {10'd0, 17'd5, 17'd6, 17'd7, 1'b1}) begin
            failures++;
            $display("FAIL nonl_rec: got %0d %0d %0d %0d done=%b expected 0 5 6 7 done=1",
                     log_addr[0], log_x[0], log_y[0], log_z[0], log_done[0]);
        end
        checks++;
        if ({count, done, error} !== {11'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL nonl_status: count=%0d done=%b error=%b expected 1 1 0", count, done, error);
        end
    endtask

    task automatic test_cr_blank();
        pulse_start();
        send_str("1,2,3\r\n\n4,5,6\n", 1'b1);
        settle();
        checks++;
        if ({n_wr[3:0], count} !== {4'd2, 11'd2}) begin
            failures++;
            $display("FAIL crblank_count: n_wr=%0d count=%0d expected 2 2", n_wr, count);
        end
        checks++;
        if ({log_addr[0], log_x[0], log_y[0], log_z[0], log_addr[1], log_x[1], log_y[1], log_z[1]} !==
            {10'd0, 17'd1, 17'd2, 17'd3, 10'd1, 17'd4, 17'd5, 17'd6}) begin
            failures++;
            $display("FAIL crblank_recs: got %0d:%0d,%0d,%0d %0d:%0d,%0d,%0d expected 0:1,2,3 1:4,5,6",
                     log_addr[0], log_x[0], log_y[0], log_z[0], log_addr[1], log_x[1], log_y[1], log_z[1]);
        end
        checks++;
        if ({done, error} !== 2'b10) begin
            failures++;
            $display("FAIL crblank_flags: done=%b error=%b expected 1 0", done, error);
        end
    endtask

    task automatic test_overflow();
        pulse_start();
        send_str("131071,0,1", 1'b1);
        settle();
        checks++;
        if ({n_wr[3:0], log_x[0], log_y[0], log_z[0], done} !== {4'd1, 17'd131071, 17'd0, 17'd1, 1'b1}) begin
            failures++;
            $display("FAIL max_coord: nwr=%0d x=%0d y=%0d z=%0d done=%b expected 1 131071 0 1 1",
                     n_wr, log_x[0], log_y[0], log_z[0], done);
        end
        pulse_start();
        send_str("131072,1,1\n", 1'b0);
        settle();
        checks++;
        if ({n_wr[3:0], error, done, err_code} !== {4'd0, 1'b1, 1'b0, 2'd2}) begin
            failures++;
            $display("FAIL overflow: nwr=%0d error=%b done=%b code=%0d expected 0 1 0 2",
                     n_wr, error, done, err_code);
        end
    endtask

    task automatic test_format();
        pulse_start();
        send_str("1,,2\n", 1'b0);
        settle();
        checks++;
        if ({n_wr[3:0], error, done, err_code} !== {4'd0, 1'b1, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL double_comma: nwr=%0d error=%b done=%b code=%0d expected 0 1 0 1",
                     n_wr, error, done, err_code);
        end
        pulse_start();
        send_str("1,2\n", 1'b0);
        settle();
        checks++;
        if ({n_wr[3:0], error, err_code} !== {4'd0, 1'b1, 2'd1}) begin
            failures++;
            $display("FAIL short_line: nwr=%0d error=%b code=%0d expected 0 1 1", n_wr, error, err_code);
        end
        pulse_start();
        send_str("1,2", 1'b1);
        settle();
        checks++;
        if ({n_wr[3:0], error, done, err_code} !== {4'd0, 1'b1, 1'b0, 2'd1}) begin
            failures++;
            $display("FAIL partial_last: nwr=%0d error=%b done=%b code=%0d expected 0 1 0 1",
                     n_wr, error, done, err_code);
        end
        pulse_start();
        send_str("1,a,3\n", 1'b0);
        settle();
        checks++;
        if ({error, err_code} !== {1'b1, 2'd1}) begin
            failures++;
            $display("FAIL bad_char: error=%b code=%0d expected 1 1", error, err_code);
        end
    endtask

    task automatic test_limit();
        pulse_start();
        send_str("1,1,1\n2,2,2\n3,3,3\n4,4,4\n5,5,5\n", 1'b0);
        settle();
        checks++;
        if (n_wr !== 4) begin
            failures++;
            $display("FAIL limit_nwr: got %0d expected 4", n_wr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({log_addr[i], log_x[i], log_y[i], log_z[i]} !==
                {10'(i), 17'(i + 1), 17'(i + 1), 17'(i + 1)}) begin
                failures++;
                $display("FAIL limit_rec%0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d", i,
                         log_addr[i], log_x[i], log_y[i], log_z[i], i, i + 1, i + 1, i + 1);
            end
        end
        checks++;
        if ({count, error, done, err_code, bif.in_ready} !== {11'd4, 1'b1, 1'b0, 2'd3, 1'b0}) begin
            failures++;
            $display("FAIL limit_status: count=%0d error=%b done=%b code=%0d ready=%b expected 4 1 0 3 0",
                     count, error, done, err_code, bif.in_ready);
        end
        checks++;
        if (wr_in_err !== 0) begin
            failures++;
            $display("FAIL wr_in_error: got %0d expected 0", wr_in_err);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_str("7,7,7\n12,3", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bif.in_ready, bif.wr_en, done, error, err_code, count} !== '0) begin
            failures++;
            $display("FAIL midreset_flags: ready=%b wr_en=%b done=%b error=%b code=%0d count=%0d expected all 0",
                     bif.in_ready, bif.wr_en, done, error, err_code, count);
        end
        checks++;
        if ({bif.wr_addr, bif.wr_x, bif.wr_y, bif.wr_z} !== '0) begin
            failures++;
            $display("FAIL midreset_data: addr=%0d x=%0d y=%0d z=%0d expected 0 0 0 0",
                     bif.wr_addr, bif.wr_x, bif.wr_y, bif.wr_z);
        end
        @(negedge clk);
        rst = 1'b1;
        pulse_start();
        send_str("9,9,9\n", 1'b1);
        settle();
        checks++;
        if ({n_wr[3:0], log_addr[0], log_x[0], log_y[0], log_z[0], done, error} !==
            {4'd1, 10'd0, 17'd9, 17'd9, 17'd9, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL midreset_resume: nwr=%0d rec=%0d %0d %0d %0d done=%b error=%b expected 1 0 9 9 9 1 0",
                     n_wr, log_addr[0], log_x[0], log_y[0], log_z[0], done, error);
        end
    endtask

    initial begin
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;
        bif.in_last  = 1'b0;
        test_reset();
        test_back_to_back();
        test_no_newline();
        test_cr_blank();
        test_overflow();
        test_format();
        test_limit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
